rsa_core_arbiter: RTL
=====================

# rsa_core_arbiter

Shares one Rsa256Core modular-exponentiation engine between two independent requesters, such as the UART/Avalon RSA wrapper and a second on-chip client. It arbitrates round-robin, latches the winner's operands, and issues a single-cycle start to the core. It returns the result, or a timeout error, to the owning requester through a valid/ready response handshake. The block sits between the requesters and the core and is the only driver of the core's start and operand inputs.

## Interface
Parameters:
- WDOG_W, 20: width of the watchdog counter.
- WDOG_LIMIT, 800000: RUN-state cycles allowed before a timeout is declared. Must be less than 2^WDOG_W.

Ports:
- avm_clk  in  1  clock.
- avm_rst  in  1  reset; asynchronous, active-high.
- r0_valid, r1_valid  in  1  request pending from requester 0 / 1.
- r0_ready, r1_ready  out  1  request accepted this cycle.
- r0_a, r0_d, r0_n, r1_a, r1_d, r1_n  in  256  base, exponent and modulus per requester.
- r0_resp_valid, r1_resp_valid  out  1  response available to the owner.
- r0_resp_ready, r1_resp_ready  in  1  owner consumes the response.
- resp_data  out  256  result: a^d mod n, or 0 on error.
- resp_err  out  1  1 = watchdog timeout.
- core_start  out  1  one-cycle start pulse to the core.
- core_a, core_d, core_n  out  256  latched operands.
- core_a_pow_d  in  256  core result.
- core_finished  in  1  core done pulse.
- busy  out  1  state is not S_IDLE.
- owner  out  1  index of the current or last granted requester.

## Operation
States: S_IDLE, S_LAUNCH, S_RUN, S_RESP, S_DRAIN.

S_IDLE:
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not last_owner wins.
- rX_ready is asserted combinationally for the winner only.
- On valid&&ready:
  - Latch that requester's a/d/n into the operand registers.
  - Set owner and last_owner to the winner.
  - Go to S_LAUNCH.

S_LAUNCH:
- core_start = 1 for exactly this cycle.
- Clear the watchdog.
- Go to S_RUN.

S_RUN:
- The watchdog increments every cycle.
- If core_finished = 1: latch resp_data = core_a_pow_d, resp_err = 0, go to S_RESP.
- Else, if the watchdog equals WDOG_LIMIT-1: resp_data = 0, resp_err = 1, go to S_DRAIN.
- When finished and the limit occur in the same cycle, finished wins.

S_DRAIN (the core is still busy):
- The owner's resp_valid is asserted, with the same handshake as S_RESP.
- The block returns to S_IDLE only once both conditions hold, in any order:
  - core_finished has been seen; its result is discarded.
  - The response has been consumed.

S_RESP:
- rX_resp_valid = 1 for the owner only.
- resp_data and resp_err are held stable until rX_resp_ready.
- Then go to S_IDLE.

Operand and output rules:
- The operand registers drive core_a/d/n continuously.
- The operand registers change only on acceptance.
- core_finished is ignored in S_IDLE, S_LAUNCH and S_RESP.
- A requester may drop valid before it is granted; no request is lost once it has been accepted.
- The non-owner's ready and resp_valid are always 0 outside S_IDLE.

## Timing
- Reset values:
  - State S_IDLE.
  - All ready, resp_valid, core_start, busy and resp_err outputs 0.
  - resp_data, core_a, core_d and core_n are 0.
  - owner = 0.
  - last_owner = 1, so requester 0 wins the first tie.
- Reset mid-operation:
  - Immediate return to the reset values.
  - The outstanding request is dropped with no response.
  - The core shares avm_rst and is reset with the block.
- Latency:
  - Acceptance at edge T.
  - core_start is high in cycle T+1.
  - core_finished sampled at edge F gives resp_valid in cycle F+1.
  - A new acceptance is possible the cycle after the response handshake.
- Timeout: resp_valid rises WDOG_LIMIT+1 cycles after core_start.
- core_start never pulses while in S_RUN or S_DRAIN, so the core is never restarted while busy.
- The watchdog saturates; it does not wrap.

## Test plan
- Single request: r0: a=4, d=7, n=33.
  - Required: r0_ready for 1 cycle, core_start 1 cycle later.
  - Core model finishes after 50 cycles with 16.
  - Required: r0_resp_valid with resp_data = 16, resp_err = 0, cleared after r0_resp_ready.
- Tie after reset: both requesters valid.
  - r0 = (4, 7, 33), r1 = (2, 3, 33).
  - Required: r0 served first (16), then r1 (8).
  - Both requesters then stay valid; required: grants alternate r0, r1, r0.
- Back-pressure: hold r1_resp_ready = 0 for 20 cycles after a result of 8.
  - Required: resp_data stays 8, r1_resp_valid stays 1, no new grant, r0_ready = 0 throughout.
- Timeout: WDOG_LIMIT = 100, core model never finishes.
  - Required: r0_resp_valid with resp_err = 1 and resp_data = 0, 101 cycles after core_start.
  - busy stays 1 until core_finished is injected; r1 is granted only afterwards.
- Edge cases:
  - core_finished in the same cycle as the watchdog limit: required result returned, resp_err = 0.
  - core_finished pulsed in S_IDLE: required to be ignored.
- avm_rst asserted during S_RUN: required all outputs zero asynchronously, state S_IDLE, and a later request processed normally.

Source files
------------

// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one Rsa256Core between two requesters, with a
// watchdog that returns a timeout error and drains a hung core before rearming.
module rsa_core_arbiter #(
  parameter int WDOG_W     = 20,
  parameter int WDOG_LIMIT = 800000
) (
  input  logic         avm_clk,
  input  logic         avm_rst,
  input  logic         r0_valid,
  input  logic         r1_valid,
  output logic         r0_ready,
  output logic         r1_ready,
  input  logic [255:0] r0_a,
  input  logic [255:0] r0_d,
  input  logic [255:0] r0_n,
  input  logic [255:0] r1_a,
  input  logic [255:0] r1_d,
  input  logic [255:0] r1_n,
  output logic         r0_resp_valid,
  output logic         r1_resp_valid,
  input  logic         r0_resp_ready,
  input  logic         r1_resp_ready,
  output logic [255:0] resp_data,
  output logic         resp_err,
  output logic         core_start,
  output logic [255:0] core_a,
  output logic [255:0] core_d,
  output logic [255:0] core_n,
  input  logic [255:0] core_a_pow_d,
  input  logic         core_finished,
  output logic         busy,
  output logic         owner
);

  localparam int DATA_W = 256;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESP, S_DRAIN} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   op_a, op_d, op_n, res_q;
  logic                err_q, owner_q, last_owner;
  logic                fin_seen, resp_taken;
  logic [WDOG_W-1:0]   wdog;
  logic                win, accept, resp_vld, resp_rdy_own;

  function automatic logic [WDOG_W-1:0] wdog_sat_inc(input logic [WDOG_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // On a tie the requester that did not win last time is granted.
  assign win          = (r0_valid && r1_valid) ? ~last_owner : r1_valid;
  assign resp_rdy_own = owner_q ? r1_resp_ready : r0_resp_ready;

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    core_start = 1'b0;
    resp_vld   = 1'b0;
    case (state)
      S_IDLE: begin
        if (r0_valid || r1_valid) begin
          accept   = 1'b1;
          r0_ready = ~win;
          r1_ready = win;
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        state_nx   = S_RUN;
      end
      S_RUN: begin
        if (core_finished)          state_nx = S_RESP;
        else if (wdog == WDOG_LAST) state_nx = S_DRAIN;
      end
      S_RESP: begin
        resp_vld = 1'b1;
        if (resp_rdy_own) state_nx = S_IDLE;
      end
      S_DRAIN: begin
        // Stay busy until the hung core finally reports, so it is never restarted mid-run.
        resp_vld = ~resp_taken;
        if ((fin_seen || core_finished) && (resp_taken || resp_rdy_own))
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state      <= S_IDLE;
      op_a       <= '0;
      op_d       <= '0;
      op_n       <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      owner_q    <= 1'b0;
      last_owner <= 1'b1;
      wdog       <= '0;
      fin_seen   <= 1'b0;
      resp_taken <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a       <= win ? r1_a : r0_a;
            op_d       <= win ? r1_d : r0_d;
            op_n       <= win ? r1_n : r0_n;
            owner_q    <= win;
            last_owner <= win;
          end
        end
        S_LAUNCH: begin
          wdog       <= '0;
          fin_seen   <= 1'b0;
          resp_taken <= 1'b0;
        end
        S_RUN: begin
          wdog <= wdog_sat_inc(wdog);
          if (core_finished) begin
            res_q <= core_a_pow_d;
            err_q <= 1'b0;
          end else if (wdog == WDOG_LAST) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (core_finished)            fin_seen   <= 1'b1;
          if (resp_vld && resp_rdy_own) resp_taken <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign r0_resp_valid = resp_vld & ~owner_q;
  assign r1_resp_valid = resp_vld & owner_q;
  assign resp_data     = res_q;
  assign resp_err      = err_q;
  assign core_a        = op_a;
  assign core_d        = op_d;
  assign core_n        = op_n;
  assign busy          = (state != S_IDLE);
  assign owner         = owner_q;

endmodule
